// File: rtl/qpoint_pkg.sv
// Shared Q-format defaults and helpers for the qmult arbiter slice.
package qpoint_pkg;

  localparam int unsigned QDefault = 23;
  localparam int unsigned NDefault = 32;

  function automatic int unsigned sign_bit(input int unsigned n);
    return n - 1;
  endfunction

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

endpackage

// File: rtl/qmult.sv
// Sign-magnitude Q-format multiplier: magnitude product shifted right by Q, truncated.
module qmult
  import qpoint_pkg::*;
#(
  parameter int unsigned Q = QDefault,
  parameter int unsigned N = NDefault
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] c
);

  localparam int unsigned SB = sign_bit(N);

  logic [2*N-3:0] prod;
  logic [2*N-3:0] prod_shr;
  logic           unused_prod;

  assign prod     = {{(N-1){1'b0}}, a[SB-1:0]} * {{(N-1){1'b0}}, b[SB-1:0]};
  assign prod_shr = prod >> Q;
  // Upper bits are dropped on purpose: the format does not saturate.
  assign unused_prod = ^prod_shr;
  assign c = {a[SB] ^ b[SB], prod_shr[N-2:0]};

endmodule

// File: rtl/rr_pick.sv
// Round-robin priority picker: first asserted req at or after ptr, with wrap-around.
module rr_pick
  import qpoint_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  idx
);

  always_comb begin
    int unsigned k;
    logic        found;
    logic [IDW-1:0] kk;
    k     = 0;
    kk    = '0;
    found = 1'b0;
    gnt   = '0;
    idx   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      k = 32'(ptr) + i;
      if (k >= NREQ) k = k - NREQ;
      kk = IDW'(k);
      if (!found && req[kk]) begin
        found   = 1'b1;
        gnt[kk] = 1'b1;
        idx     = kk;
      end
    end
  end

endmodule

// File: rtl/qmult_arbiter.sv
// Round-robin sharing of one qmult among NREQ requesters with a valid/ready result register.
// Define QMULT_ARB_STATS_EN to add the o_op_cnt / o_stall_cnt counters.
module qmult_arbiter
  import qpoint_pkg::*;
#(
  parameter int unsigned Q    = QDefault,
  parameter int unsigned N    = NDefault,
  parameter int unsigned NREQ = 4,
  localparam int unsigned IDW = clog2(NREQ)
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [NREQ-1:0] i_req,
  input  logic [NREQ*N-1:0] i_a_flat,
  input  logic [NREQ*N-1:0] i_b_flat,
  output logic [NREQ-1:0] o_gnt,
  output logic            o_valid,
  output logic [IDW-1:0]  o_id,
  output logic [N-1:0]    o_result,
`ifdef QMULT_ARB_STATS_EN
  output logic [31:0]     o_op_cnt,
  output logic [31:0]     o_stall_cnt,
`endif
  input  logic            i_rdy
);

  logic            valid_q, valid_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [N-1:0]    result_q, result_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [NREQ-1:0] pick_gnt;
  logic [IDW-1:0]  pick_idx;
  logic [N-1:0]    a_sel, b_sel, prod;
  logic            accept;

  rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .req (i_req),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  assign a_sel = i_a_flat[pick_idx*N +: N];
  assign b_sel = i_b_flat[pick_idx*N +: N];

  qmult #(Q, N) u_qmult (a_sel, b_sel, prod);

  // No grant may escape during a reset cycle.
  assign accept = (|i_req) & (~valid_q | i_rdy) & ~i_rst;
  assign o_gnt  = accept ? pick_gnt : '0;

  always_comb begin
    valid_d  = valid_q;
    id_d     = id_q;
    result_d = result_q;
    ptr_d    = ptr_q;
    if (accept) begin
      valid_d  = 1'b1;
      id_d     = pick_idx;
      result_d = prod;
      ptr_d    = (pick_idx == IDW'(NREQ - 1)) ? '0 : pick_idx + IDW'(1);
    end else if (valid_q && i_rdy) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_q  <= 1'b0;
      id_q     <= '0;
      result_q <= '0;
      ptr_q    <= '0;
    end else begin
      valid_q  <= valid_d;
      id_q     <= id_d;
      result_q <= result_d;
      ptr_q    <= ptr_d;
    end
  end

  assign o_valid  = valid_q;
  assign o_id     = id_q;
  assign o_result = result_q;

`ifdef QMULT_ARB_STATS_EN
  logic [31:0] op_cnt_q, stall_cnt_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      op_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (accept) op_cnt_q <= op_cnt_q + 32'd1;
      if (valid_q && !i_rdy && (|i_req)) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign o_op_cnt    = op_cnt_q;
  assign o_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_qmult_arbiter.sv
// Directed bench for qmult_arbiter with a result scoreboard fed at grant time.
module tb_qmult_arbiter;

  typedef struct packed {
    logic [1:0]  id;
    logic [31:0] res;
  } exp_t;

  logic         clk;
  logic         rst;
  logic [3:0]   req;
  logic [127:0] a_flat, b_flat;
  logic [3:0]   gnt;
  logic         valid;
  logic [1:0]   id;
  logic [31:0]  result;
  logic         rdy;
`ifdef QMULT_ARB_STATS_EN
  logic [31:0]  op_cnt, stall_cnt;
`endif

  logic [31:0] exp_prod [4];
  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;

  qmult_arbiter #(
    .Q    (23),
    .N    (32),
    .NREQ (4)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req       (req),
    .i_a_flat    (a_flat),
    .i_b_flat    (b_flat),
    .o_gnt       (gnt),
    .o_valid     (valid),
    .o_id        (id),
    .o_result    (result),
`ifdef QMULT_ARB_STATS_EN
    .o_op_cnt    (op_cnt),
    .o_stall_cnt (stall_cnt),
`endif
    .i_rdy       (rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got %08h want %08h", name, act, want);
    end
  endtask

  task automatic set_op(input int k, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] e);
    a_flat[k*32 +: 32] = a;
    b_flat[k*32 +: 32] = b;
    exp_prod[k]        = e;
  endtask

  // Drive one cycle's inputs just after the edge, then check the grant mid-cycle.
  task automatic step(input logic [3:0] r, input logic rd, input logic rs,
                      input logic [3:0] exp_gnt, input string name);
    exp_t e;
    @(posedge clk);
    #1;
    req = r;
    rdy = rd;
    rst = rs;
    @(negedge clk);
    chk(name, {28'd0, gnt}, {28'd0, exp_gnt});
    for (int i = 0; i < 4; i++) begin
      if (exp_gnt[i]) begin
        e.id  = 2'(i);
        e.res = exp_prod[i];
        sb.push_back(e);
      end
    end
  endtask

  // Monitor: every consumed result must match the oldest expected entry.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && valid && rdy) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected got id %0d res %08h want none", id, result);
      end else begin
        e = sb.pop_front();
        chk("sb_id", {30'd0, id}, {30'd0, e.id});
        chk("sb_res", result, e.res);
      end
    end
  end

  initial begin
    rst = 1'b1;
    req = '0;
    rdy = 1'b1;
    a_flat = '0;
    b_flat = '0;
    set_op(0, 32'h2010_0000, 32'h8060_0000, 32'h980C_0000); // 64.125 * -0.75
    set_op(1, 32'h0080_0000, 32'h0100_0000, 32'h0100_0000); // 1.0 * 2.0
    set_op(2, 32'h8180_0000, 32'h8100_0000, 32'h0300_0000); // -3.0 * -2.0
    set_op(3, 32'h0040_0000, 32'h8040_0000, 32'h8020_0000); // 0.5 * -0.5

    step(4'b1111, 1'b1, 1'b1, 4'b0000, "rst_gnt0");
    step(4'b1111, 1'b1, 1'b1, 4'b0000, "rst_gnt1");
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_id", {30'd0, id}, 32'd0);
    chk("rst_result", result, 32'd0);

    // Single multiply, then drain
    step(4'b0001, 1'b1, 1'b0, 4'b0001, "t1_gnt");
    step(4'b0000, 1'b1, 1'b0, 4'b0000, "t1_idle");
    chk("t1_valid", {31'd0, valid}, 32'd1);
    step(4'b0000, 1'b1, 1'b0, 4'b0000, "t1_idle2");
    chk("t1_drained", {31'd0, valid}, 32'd0);
    step(4'b0000, 1'b1, 1'b1, 4'b0000, "t1_rst");

    // Full rotation
    step(4'b1111, 1'b1, 1'b0, 4'b0001, "t2_g0");
    step(4'b1111, 1'b1, 1'b0, 4'b0010, "t2_g1");
    step(4'b1111, 1'b1, 1'b0, 4'b0100, "t2_g2");
    step(4'b1111, 1'b1, 1'b0, 4'b1000, "t2_g3");
    step(4'b1111, 1'b1, 1'b0, 4'b0001, "t2_g4");

    // Wrap-around from pointer 2
    step(4'b0010, 1'b1, 1'b0, 4'b0010, "t3_p2");
    step(4'b1011, 1'b1, 1'b0, 4'b1000, "t3_g3");
    step(4'b1011, 1'b1, 1'b0, 4'b0001, "t3_wrap");

    // Stall three cycles, then resume
    for (int i = 0; i < 3; i++) begin
      step(4'b1111, 1'b0, 1'b0, 4'b0000, "t4_stall_gnt");
      chk("t4_stall_valid", {31'd0, valid}, 32'd1);
      chk("t4_stall_id", {30'd0, id}, 32'd0);
      chk("t4_stall_res", result, 32'h980C_0000);
    end
    step(4'b1111, 1'b1, 1'b0, 4'b0010, "t4_resume");
    step(4'b0000, 1'b1, 1'b0, 4'b0000, "t4_drain");
`ifdef QMULT_ARB_STATS_EN
    chk("t4_op_cnt", op_cnt, 32'd9);
    chk("t4_stall_cnt", stall_cnt, 32'd3);
`endif

    // Truncation of fraction bits and silent magnitude overflow
    set_op(1, 32'h0000_0003, 32'h00C0_0000, 32'h0000_0004);
    set_op(2, 32'h4000_0000, 32'h4000_0000, 32'h0000_0000);
    step(4'b0110, 1'b1, 1'b0, 4'b0100, "t5_ovf_gnt");
    step(4'b0110, 1'b1, 1'b0, 4'b0010, "t5_trunc_gnt");
    step(4'b0000, 1'b1, 1'b0, 4'b0000, "t5_idle");

    // Reset with a result pending
    step(4'b1111, 1'b1, 1'b0, 4'b0100, "t6_pre");
    step(4'b1111, 1'b0, 1'b1, 4'b0000, "t6_rst_gnt");
    step(4'b1111, 1'b0, 1'b1, 4'b0000, "t6_rst_hold");
    chk("t6_valid", {31'd0, valid}, 32'd0);
    sb.delete();
    step(4'b1111, 1'b1, 1'b0, 4'b0001, "t6_first");
    step(4'b0000, 1'b1, 1'b0, 4'b0000, "t6_idle");
`ifdef QMULT_ARB_STATS_EN
    chk("t6_op_cnt", op_cnt, 32'd1);
    chk("t6_stall_cnt", stall_cnt, 32'd0);
`endif
    step(4'b0000, 1'b1, 1'b0, 4'b0000, "t6_idle2");
    chk("end_valid", {31'd0, valid}, 32'd0);
    chk("end_sb_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
